// File: rtl/nes_pad_reader.sv
// NES gamepad poller: latches the pad, shifts out 8 buttons, and commits a
// report only when two consecutive polls read the same value.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for the poll timer to wrap
// LATCH    | pad_latch high for LATCH_CYCLES
// FIRST    | settle HALF_BIT after latch, then sample bit 0 (A)
// CLK_LO   | pad_clk low for HALF_BIT
// CLK_HI   | pad_clk high for HALF_BIT, then sample the next bit
// COMMIT   | compare against the previous poll and publish on agreement
module nes_pad_reader #(
    parameter int POLL_DIV     = 833333,
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_BIT     = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] controller_report,
    output logic       report_valid,
    output logic       start_rise,
    output logic       busy
);

    localparam int TIMER_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int CNT_MAX = ((LATCH_CYCLES > HALF_BIT) ? LATCH_CYCLES : HALF_BIT) - 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
    localparam logic [CNT_W-1:0]   LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HALF_LOAD  = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_FIRST,
        S_CLK_LO,
        S_CLK_HI,
        S_COMMIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] poll_timer;
    logic [CNT_W-1:0]   phase_cnt;
    logic [2:0]         bit_cnt;
    logic [1:0]         sync_q;
    logic [7:0]         raw;
    logic [7:0]         prev_raw;
    logic               poll_start;
    logic               phase_done;
    logic               sample_now;

    assign poll_start = enable && (poll_timer == TIMER_LAST) && (state == S_IDLE);
    assign phase_done = (phase_cnt == '0);
    assign sample_now = phase_done && ((state == S_FIRST) || (state == S_CLK_HI));

    // Released pad reads high, so the synchroniser idles at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pad_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_timer <= '0;
        end else if (!enable || (poll_timer == TIMER_LAST)) begin
            poll_timer <= '0;
        end else begin
            poll_timer <= poll_timer + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (poll_start) state_nxt = S_LATCH;
            S_LATCH:  if (phase_done) state_nxt = S_FIRST;
            S_FIRST:  if (phase_done) state_nxt = S_CLK_LO;
            S_CLK_LO: if (phase_done) state_nxt = S_CLK_HI;
            S_CLK_HI: begin
                if (phase_done) begin
                    state_nxt = (bit_cnt == 3'd7) ? S_COMMIT : S_CLK_LO;
                end
            end
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pad_latch = (state == S_LATCH);
        pad_clk   = (state != S_CLK_LO);
        busy      = (state != S_IDLE);
    end

    // Phase timer reloads on every state change and counts down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (state_nxt != state) begin
            phase_cnt <= (state_nxt == S_LATCH) ? LATCH_LOAD : HALF_LOAD;
        end else if (!phase_done) begin
            phase_cnt <= phase_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            raw     <= '0;
        end else if (poll_start) begin
            bit_cnt <= '0;
        end else if (sample_now) begin
            bit_cnt <= bit_cnt + 3'd1;
            raw     <= {raw[6:0], ~sync_q[1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_raw          <= '0;
            controller_report <= '0;
            report_valid      <= 1'b0;
            start_rise        <= 1'b0;
        end else begin
            report_valid <= 1'b0;
            start_rise   <= 1'b0;
            if (state == S_COMMIT) begin
                prev_raw <= raw;
                if (raw == prev_raw) begin
                    controller_report <= raw;
                    report_valid      <= 1'b1;
                    start_rise        <= raw[4] & ~controller_report[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural pad model that
// presents the next button each time pad_clk falls.
module tb_nes_pad_reader;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] controller_report;
    logic       report_valid;
    logic       start_rise;
    logic       busy;

    logic [7:0] pad_buttons;
    logic       glitch;
    logic       pad_bit;
    int         pad_idx;

    int total;
    int bad;

    nes_pad_reader #(
        .POLL_DIV(100),
        .LATCH_CYCLES(4),
        .HALF_BIT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pad_data(pad_data),
        .pad_latch(pad_latch),
        .pad_clk(pad_clk),
        .controller_report(controller_report),
        .report_valid(report_valid),
        .start_rise(start_rise),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad: latch reloads to A; each pad_clk fall advances to the next button.
    always @(posedge pad_latch or negedge pad_clk) begin
        if (pad_latch) pad_idx <= 0;
        else           pad_idx <= pad_idx + 1;
    end

    always_comb begin
        pad_bit = 1'b1;
        if (pad_idx >= 0 && pad_idx < 8) pad_bit = ~pad_buttons[3'(7 - pad_idx)];
    end

    assign pad_data = glitch ? 1'b0 : pad_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (pad_latch) break;
        end
    endtask

    // Called one step after the first LATCH cycle; runs until one cycle past busy falling.
    task automatic measure_poll(input bit do_glitch, output int latch_len, output int pulses,
                                output int lo_bad, output int busy_len,
                                output int valid_cnt, output int rise_cnt);
        int lo_run;
        bit prev_clk;
        bit done;
        latch_len = 0; pulses = 0; lo_bad = 0; busy_len = 0;
        valid_cnt = 0; rise_cnt = 0; lo_run = 0; prev_clk = 1'b1; done = 1'b0;
        for (int g = 0; g < 200 && !done; g++) begin
            if (pad_latch) latch_len++;
            if (busy) busy_len++;
            if (!pad_clk) begin
                lo_run++;
            end else if (lo_run > 0) begin
                pulses++;
                if (lo_run != 2) lo_bad++;
                lo_run = 0;
            end
            valid_cnt += int'(report_valid);
            rise_cnt  += int'(start_rise);
            if (!busy) done = 1'b1;
            glitch   = do_glitch && ((g == 0) || (!pad_clk && prev_clk));
            prev_clk = pad_clk;
            @(posedge clk);
            #1;
        end
        glitch = 1'b0;
        valid_cnt += int'(report_valid);
        rise_cnt  += int'(start_rise);
        check("poll_completes", 32'(done), 32'd1);
    endtask

    initial begin
        int n, ll, pu, lb, bl, vc, rc, falls, latches;
        int vsum;
        bit prev;
        total = 0; bad = 0;
        reset = 1'b1; enable = 1'b0; glitch = 1'b0; pad_buttons = 8'h90;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pad_latch", 32'(pad_latch), 32'd0);
        check("rst_pad_clk", 32'(pad_clk), 32'd1);
        check("rst_report", 32'(controller_report), 32'h00);
        check("rst_valid", 32'(report_valid), 32'd0);
        check("rst_start_rise", 32'(start_rise), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;

        // Scenario 1: A+Start, two polls to commit
        wait_latch(n);
        check("s1_first_latch_delay", 32'(n), 32'd100);
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        check("s1_latch_len", 32'(ll), 32'd4);
        check("s1_clk_pulses", 32'(pu), 32'd7);
        check("s1_clk_lo_width_bad", 32'(lb), 32'd0);
        check("s1_busy_len", 32'(bl), 32'd35);
        check("s1_poll1_valid", 32'(vc), 32'd0);
        wait_latch(n);
        check("s1_period_latch", 32'(n), 32'd64);
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        check("s1_poll2_valid", 32'(vc), 32'd1);
        check("s1_poll2_rise", 32'(rc), 32'd1);
        check("s1_poll2_report", 32'(controller_report), 32'h90);

        // Scenario 2: Start held, then released for two polls
        wait_latch(n);
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        check("s2_hold_valid", 32'(vc), 32'd1);
        check("s2_hold_rise", 32'(rc), 32'd0);
        check("s2_hold_report", 32'(controller_report), 32'h90);
        pad_buttons = 8'h00;
        wait_latch(n);
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        check("s2_rel1_valid", 32'(vc), 32'd0);
        check("s2_rel1_report", 32'(controller_report), 32'h90);
        wait_latch(n);
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        check("s2_rel2_valid", 32'(vc), 32'd1);
        check("s2_rel2_report", 32'(controller_report), 32'h00);

        // Scenario 3: alternating patterns never agree
        vsum = 0;
        for (int p = 0; p < 4; p++) begin
            pad_buttons = (p % 2 == 0) ? 8'h01 : 8'h02;
            wait_latch(n);
            measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
            vsum += vc;
        end
        check("s3_alt_valid_total", 32'(vsum), 32'd0);
        check("s3_alt_report", 32'(controller_report), 32'h00);

        // Scenario 4: one-cycle low glitches off the sample points
        pad_buttons = 8'h00;
        wait_latch(n);
        measure_poll(1'b1, ll, pu, lb, bl, vc, rc);
        check("s4_glitch1_valid", 32'(vc), 32'd0);
        wait_latch(n);
        measure_poll(1'b1, ll, pu, lb, bl, vc, rc);
        check("s4_glitch2_valid", 32'(vc), 32'd1);
        check("s4_glitch_report", 32'(controller_report), 32'h00);

        // Scenario 5: commit 0x90, then reset during bit 3's CLK_LO
        pad_buttons = 8'h90;
        for (int p = 0; p < 2; p++) begin
            wait_latch(n);
            measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        end
        check("s5_pre_report", 32'(controller_report), 32'h90);
        wait_latch(n);
        falls = 0;
        prev = pad_clk;
        for (int g = 0; g < 100 && falls < 3; g++) begin
            @(posedge clk);
            #1;
            if (!pad_clk && prev) falls++;
            prev = pad_clk;
        end
        check("s5_reached_bit3_lo", 32'(pad_clk), 32'd0);
        reset = 1'b1;
        #1;
        check("s5_rst_pad_clk", 32'(pad_clk), 32'd1);
        check("s5_rst_pad_latch", 32'(pad_latch), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_report", 32'(controller_report), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_latch(n);
        check("s5_latch_after_reset", 32'(n), 32'd100);
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        check("s5_first_poll_valid", 32'(vc), 32'd0);

        // Scenario 6: enable drops during LATCH
        wait_latch(n);
        enable = 1'b0;
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);
        check("s6_latch_len", 32'(ll), 32'd4);
        check("s6_busy_len", 32'(bl), 32'd35);
        check("s6_valid", 32'(vc), 32'd1);
        check("s6_rise", 32'(rc), 32'd1);
        check("s6_report", 32'(controller_report), 32'h90);
        latches = 0;
        for (int g = 0; g < 500; g++) begin
            @(posedge clk);
            #1;
            if (pad_latch) latches++;
        end
        check("s6_no_latch_disabled", 32'(latches), 32'd0);
        enable = 1'b1;
        wait_latch(n);
        check("s6_reenable_delay", 32'(n), 32'd100);
        measure_poll(1'b0, ll, pu, lb, bl, vc, rc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
